// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_memory family: default sizes, word type,
// output-buffer occupancy encoding and the read-side pop admission rule.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] fifo_word_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    // Room exists when buffered + in-flight words, less the one leaving now, is below 2.
    function automatic logic has_room(input logic [1:0] count,
                                      input logic       inflight,
                                      input logic       pop);
        logic [2:0] occupancy;
        occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        return occupancy < 3'd2;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_buffer.sv
// Two-entry output register buffer: head drives the stream, tail holds the
// second word; occupancy is the state of a small two-process FSM.
module stream_out_buffer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  valid,
    output logic [1:0]            count
);

    buf_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                // Simultaneous push and pop: the new word becomes head, count stays 1.
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d  = push_data;
                    state_d = BUF_FULL;
                end else if (pop) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        state_d = BUF_ONE;
                    end
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    assign head_data = head_q;
    assign valid     = (state_q != BUF_EMPTY);
    assign count     = state_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for fifo_memory: issues pops, tracks the word in flight
// through the 1-cycle read latency, and presents a valid/ready stream.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read_enable,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    logic       inflight_q;
    logic [1:0] buf_count;
    logic       pop_out;

    assign pop_out = m_valid && m_ready;

    // rstn gates the pop so nothing is requested while the buffer is held in reset.
    assign fifo_read_enable = rstn && enable && !fifo_empty
                              && has_room(buf_count, inflight_q, pop_out);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_read_enable;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xfer_count <= '0;
        end else if (pop_out) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end

    stream_out_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rstn     (rstn),
        .push     (inflight_q),
        .push_data(fifo_read_data),
        .pop      (pop_out),
        .head_data(m_data),
        .valid    (m_valid),
        .count    (buf_count)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomised checks of fifo_stream_reader against a behavioural
// FIFO memory model and an in-order scoreboard.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic        fifo_read_enable;
    logic [7:0]  fifo_read_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic [15:0] xfer_count;

    logic        rd_en4;
    logic        m_valid4;
    logic [7:0]  m_data4;
    logic [3:0]  xfer4;

    int vectors = 0;
    int miscompares = 0;
    int pops = 0;
    int delivered = 0;

    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    int         qn = 0;

    typedef struct {
        logic        push_en;
        logic [7:0]  push_data;
        logic        en;
        logic        rdy;
        logic        exp_rd;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [15:0] exp_xfer;
    } vec_t;

    vec_t tv[14];

    assign fifo_empty = (qn == 0);

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_read_enable(fifo_read_enable), .fifo_read_data(fifo_read_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .xfer_count(xfer_count)
    );

    // Narrow-counter instance sees identical inputs, so only its counter width differs.
    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rstn(rstn), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_read_enable(rd_en4), .fifo_read_data(fifo_read_data),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .xfer_count(xfer4)
    );

    always @(posedge clk) begin
        if (fifo_read_enable) begin
            if (q.size() > 0) fifo_read_data <= q.pop_front();
            qn <= qn - 1;
        end
    end

    always @(posedge clk) begin
        if (rstn) begin
            if (fifo_read_enable) pops++;
            if (fifo_read_enable && fifo_empty) begin
                miscompares++;
                $display("FAIL pop_while_empty: read_enable=1 fifo_empty=1 at %0t", $time);
            end
            if (m_valid && m_ready) begin
                vectors++;
                delivered++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_extra: got %02h, expected no word", m_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        miscompares++;
                        $display("FAIL scoreboard_order: got %02h expected %02h", m_data, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        q.push_back(w);
        exp_q.push_back(w);
        qn = qn + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        enable = 1'b0;
        m_ready = 1'b0;
        q.delete();
        exp_q.delete();
        qn = 0;
        repeat (2) @(negedge clk);
        pops = 0;
        delivered = 0;
        rstn = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
        tv[1]  = '{1'b1, 8'hA1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0};
        tv[2]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0};
        tv[3]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 16'd0};
        tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 16'd0};
        tv[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 16'd0};
        tv[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 16'd1};
        tv[7]  = '{1'b1, 8'hA4, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 16'd2};
        tv[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd3};
        tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 16'd3};
        tv[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd3};
        tv[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA4, 16'd3};
        tv[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA4, 16'd3};
        tv[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd4};

        // Reset values and the cycle-by-cycle table.
        do_reset();
        #1;
        check("reset_valid", 32'(m_valid), 32'd0);
        check("reset_data", 32'(m_data), 32'd0);
        check("reset_xfer", 32'(xfer_count), 32'd0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (tv[i].push_en) push(tv[i].push_data);
            enable = tv[i].en;
            m_ready = tv[i].rdy;
            #1;
            check($sformatf("tv%0d_rd_en", i), 32'(fifo_read_enable), 32'(tv[i].exp_rd));
            check($sformatf("tv%0d_valid", i), 32'(m_valid), 32'(tv[i].exp_valid));
            if (tv[i].exp_valid) check($sformatf("tv%0d_data", i), 32'(m_data), 32'(tv[i].exp_data));
            check($sformatf("tv%0d_xfer", i), 32'(xfer_count), 32'(tv[i].exp_xfer));
        end

        // Streaming 0x01..0x10 with m_ready held high.
        do_reset();
        m_ready = 1'b1;
        @(negedge clk);
        for (int w = 1; w <= 16; w++) push(8'(w));
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k <= 18; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (k <= 15) check($sformatf("stream_rd_en_%0d", k), 32'(fifo_read_enable), 32'd1);
            if (k == 16) check("stream_rd_en_drop", 32'(fifo_read_enable), 32'd0);
            if (k < 2) check($sformatf("stream_latency_%0d", k), 32'(m_valid), 32'd0);
            if (k >= 2 && k <= 17) begin
                check($sformatf("stream_valid_%0d", k), 32'(m_valid), 32'd1);
                check($sformatf("stream_data_%0d", k), 32'(m_data), 32'(k - 1));
            end
            if (k == 18) begin
                check("stream_valid_end", 32'(m_valid), 32'd0);
                check("stream_xfer", 32'(xfer_count), 32'd16);
            end
        end

        // Seventeenth word: the 4-bit counter wraps to 1.
        push(8'h55);
        for (int c = 0; c < 10 && xfer_count != 16'd17; c++) @(negedge clk);
        #1;
        check("wrap_xfer16", 32'(xfer_count), 32'd17);
        check("wrap_xfer4", 32'(xfer4), 32'd1);

        // Reset while two words sit in the buffer.
        @(negedge clk);
        m_ready = 1'b0;
        for (int w = 0; w < 4; w++) push(8'h61 + 8'(w));
        repeat (4) @(negedge clk);
        #1;
        check("midrst_pre_valid", 32'(m_valid), 32'd1);
        check("midrst_pre_data", 32'(m_data), 32'h61);
        check("midrst_pre_rd_en", 32'(fifo_read_enable), 32'd0);
        m_ready = 1'b1;
        #1;
        rstn = 1'b0;
        #1;
        check("midrst_valid", 32'(m_valid), 32'd0);
        check("midrst_data", 32'(m_data), 32'd0);
        check("midrst_xfer", 32'(xfer_count), 32'd0);
        check("midrst_rd_en", 32'(fifo_read_enable), 32'd0);
        q.delete();
        exp_q.delete();
        qn = 0;
        @(negedge clk);
        rstn = 1'b1;
        pops = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("postrst_rd_en_%0d", k), 32'(fifo_read_enable), 32'd0);
            check($sformatf("postrst_valid_%0d", k), 32'(m_valid), 32'd0);
        end

        // Backpressure: exactly two pops, head held until ready rises.
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        for (int w = 1; w <= 16; w++) push(8'(w));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (k >= 2) begin
                check($sformatf("bp_hold_valid_%0d", k), 32'(m_valid), 32'd1);
                check($sformatf("bp_hold_data_%0d", k), 32'(m_data), 32'h01);
            end
        end
        check("bp_pops", 32'(pops), 32'd2);
        check("bp_rd_en", 32'(fifo_read_enable), 32'd0);
        m_ready = 1'b1;
        for (int c = 0; c < 100 && (exp_q.size() != 0 || m_valid); c++) @(negedge clk);
        check("bp_delivered", 32'(delivered), 32'd16);
        check("bp_left", 32'(exp_q.size()), 32'd0);

        // enable low for five cycles mid-stream.
        do_reset();
        m_ready = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 12; w++) push(8'hC0 + 8'(w));
        repeat (4) @(negedge clk);
        enable = 1'b0;
        begin
            int pops_at_stop;
            #1;
            pops_at_stop = pops;
            for (int k = 0; k < 5; k++) begin
                check($sformatf("en0_rd_en_%0d", k), 32'(fifo_read_enable), 32'd0);
                @(negedge clk);
                #1;
            end
            check("en0_no_pops", 32'(pops), 32'(pops_at_stop));
            check("en0_drained", 32'(m_valid), 32'd0);
            check("en0_all_out", 32'(delivered), 32'(pops));
        end
        enable = 1'b1;
        #1;
        check("en1_resume_rd_en", 32'(fifo_read_enable), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        check("en1_refill_valid", 32'(m_valid), 32'd1);
        for (int c = 0; c < 100 && (exp_q.size() != 0 || m_valid); c++) @(negedge clk);
        check("en_delivered", 32'(delivered), 32'd12);

        // Random traffic and random backpressure.
        do_reset();
        enable = 1'b1;
        begin
            int pushed;
            pushed = 0;
            for (int c = 0; c < 20000 && (pushed < 1000 || exp_q.size() != 0 || m_valid); c++) begin
                @(negedge clk);
                m_ready = 1'($urandom_range(0, 1));
                if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                    push(8'($urandom_range(0, 255)));
                    pushed++;
                end
            end
        end
        check("rand_delivered", 32'(delivered), 32'd1000);
        check("rand_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
